fifo_rd_ctrl: RTL and testbench
===============================

// Module: fifo_rd_ctrl
// PURPOSE
//  Read-domain pointer/flag controller for the async FIFO. Generalises the basic read-pointer
//  block: gray-to-binary decode of the synced write pointer, registered empty/almost_empty,
//  fill level, underflow pulse, and a first-word-fall-through (FWFT) mode. Drives the read
//  port of a 1-cycle-latency synchronous dual-port RAM. Sits opposite the write controller.
// PARAMETERS
//  ADDR_WIDTH     4   RAM address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
//  AEMPTY_THRESH  2   almost_empty asserted when RAM level <= this value (0..2**ADDR_WIDTH)
//  FWFT           0   0 = standard (data one cycle after pop); 1 = first-word-fall-through
// PORTS
//  clk           in   1       read-domain clock
//  rst           in   1       asynchronous, active-high reset
//  rd_en         in   1       pop request
//  wr_gray_sync  in   AW+1    write pointer, gray coded, already 2-flop synced into clk
//  rd_addr       out  AW      RAM read address (= rd_bin[AW-1:0])
//  mem_rd_en     out  1       RAM read strobe (combinational)
//  rd_gray       out  AW+1    registered read pointer, gray, to write-domain synchroniser
//  empty         out  1       registered; FWFT=1: no valid word at output
//  almost_empty  out  1       registered
//  dout_valid    out  1       FWFT=1: RAM output holds head word; FWFT=0: tied 0
//  rd_level      out  AW+1    registered count of words in RAM not yet fetched
//  underflow     out  1       1-cycle pulse: rd_en while empty
// BEHAVIOUR
//  Reset (async): rd_bin=0, rd_gray=0, empty=1, almost_empty=1, rd_level=0, dout_valid=0,
//   underflow=0. Reset mid-operation discards any prefetched word; no RAM read issued in reset.
//  Internal: ram_empty reg (reset 1); wr_bin_sync = gray2bin(wr_gray_sync), combinational XOR chain.
//  FWFT=0:
//   - fetch = rd_en & ~ram_empty; mem_rd_en = fetch; RAM data valid the cycle after fetch.
//   - empty = ram_empty.
//  FWFT=1:
//   - fetch = ~ram_empty & (~dout_valid | rd_en).
//   - dout_valid next = fetch | (dout_valid & ~rd_en); empty = ~dout_valid.
//   - pop of the displayed word = rd_en & dout_valid; a pop and a refetch may coincide (back-to-back).
//   - first write into an empty FIFO: dout_valid rises 1 cycle after ram_empty falls.
//  Pointer update on every clk: rd_bin_next = rd_bin + fetch (mod 2**(AW+1));
//   rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1); rd_bin <= rd_bin_next; rd_gray <= rd_gray_next.
//  Flags (all registered, computed from next values):
//   - ram_empty <= (rd_gray_next == wr_gray_sync)
//   - rd_level <= wr_bin_sync - rd_bin_next, modulo 2**(AW+1); wrap-around of either pointer is
//     transparent; never exceeds 2**AW given a correct writer.
//   - almost_empty <= (wr_bin_sync - rd_bin_next) <= AEMPTY_THRESH
//  underflow <= rd_en & empty (registered pulse, one cycle after the offending request).
//   A blocked request never moves the pointer.
//  Write-side advances are seen only via wr_gray_sync (pessimistic: flags may lag, never lead).
//  Pointer MSB distinguishes full from empty; read side only ever uses equality for empty.
// TESTING
//  1 Reset, AW=4: assert rst mid-stream -> all outputs at reset values immediately, no clk needed.
//  2 FWFT=0: wr_gray_sync 0->gray(3); rd_en 3 cycles -> rd_addr 0,1,2; mem_rd_en 3 cycles;
//    rd_level 3,2,1,0; empty=1 after 3rd pop; almost_empty=1 once level<=2.
//  3 Underflow: empty=1, rd_en=1 for 2 cycles -> underflow high 2 cycles, rd_bin stays 0.
//  4 Wrap: run 40 write/read pairs through AW=4 -> rd_bin wraps 31->0, rd_gray 5'b10000->0,
//    empty/level correct across wrap; rd_gray changes exactly one bit per fetch.
//  5 FWFT=1: write 1 word -> mem_rd_en pulses alone, dout_valid=1 next cycle, empty=0;
//    hold rd_en with 4 words -> 4 consecutive fetches, dout_valid continuous, then empty=1.
//  6 Level check: random write/read traffic vs scoreboard -> rd_level equals model each cycle
//    and almost_empty == (model_level <= AEMPTY_THRESH); no pop ever while ram_empty.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller for the async FIFO.
// Drives the read port of a 1-cycle-latency RAM, with optional first-word-fall-through.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH    = 4,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wr_gray_sync,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH:0]   rd_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  dout_valid,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AE_THRESH = PW'(AEMPTY_THRESH);

  logic [ADDR_WIDTH:0] rd_bin;
  logic [ADDR_WIDTH:0] rd_bin_next;
  logic [ADDR_WIDTH:0] rd_gray_next;
  logic [ADDR_WIDTH:0] wr_bin_sync;
  logic [ADDR_WIDTH:0] level_next;
  logic                ram_empty;
  logic                fetch;
  logic                dout_valid_next;

  // Each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    wr_bin_sync = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      wr_bin_sync[i] = ^(wr_gray_sync >> i);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Prefetch whenever the output slot is free or being popped this cycle.
      assign fetch           = ~ram_empty & (~dout_valid | rd_en);
      assign dout_valid_next = fetch | (dout_valid & ~rd_en);
      assign empty           = ~dout_valid;
    end else begin : g_std
      assign fetch           = rd_en & ~ram_empty;
      assign dout_valid_next = 1'b0;
      assign empty           = ram_empty;
    end
  endgenerate

  assign mem_rd_en    = fetch;
  assign rd_addr      = rd_bin[ADDR_WIDTH-1:0];
  assign rd_bin_next  = rd_bin + {{ADDR_WIDTH{1'b0}}, fetch};
  assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
  assign level_next   = wr_bin_sync - rd_bin_next;

  // Flags are computed from the next pointer so they are exact the cycle after a fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bin       <= '0;
      rd_gray      <= '0;
      ram_empty    <= 1'b1;
      rd_level     <= '0;
      almost_empty <= 1'b1;
      dout_valid   <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      rd_bin       <= rd_bin_next;
      rd_gray      <= rd_gray_next;
      ram_empty    <= (rd_gray_next == wr_gray_sync);
      rd_level     <= level_next;
      almost_empty <= (level_next <= AE_THRESH);
      dout_valid   <= dout_valid_next;
      underflow    <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: standard and FWFT instances share one cycle model,
// and fetched addresses are scoreboarded against the order words were written.
module tb_fifo_rd_ctrl;

  localparam int AW     = 4;
  localparam int THRESH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en = 1'b0;
  logic          sel = 1'b0;
  logic [AW:0]   wr_gray = '0;

  logic [AW-1:0] a_addr, b_addr, rd_addr;
  logic          a_mem, b_mem, mem_rd_en;
  logic [AW:0]   a_gray, b_gray, rd_gray;
  logic          a_empty, b_empty, empty;
  logic          a_ae, b_ae, almost_empty;
  logic          a_dv, b_dv, dout_valid;
  logic [AW:0]   a_level, b_level, rd_level;
  logic          a_uf, b_uf, underflow;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] sb_q[$];
  logic [AW:0]   m_wr, m_rd, m_level;
  logic          m_ram_empty, m_ae, m_uf, m_dv, m_empty, m_fetch, m_rd_req;

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .AEMPTY_THRESH(THRESH), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .rd_en(rd_en & ~sel), .wr_gray_sync(wr_gray),
    .rd_addr(a_addr), .mem_rd_en(a_mem), .rd_gray(a_gray), .empty(a_empty),
    .almost_empty(a_ae), .dout_valid(a_dv), .rd_level(a_level), .underflow(a_uf)
  );

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .AEMPTY_THRESH(THRESH), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .rd_en(rd_en & sel), .wr_gray_sync(wr_gray),
    .rd_addr(b_addr), .mem_rd_en(b_mem), .rd_gray(b_gray), .empty(b_empty),
    .almost_empty(b_ae), .dout_valid(b_dv), .rd_level(b_level), .underflow(b_uf)
  );

  assign rd_addr      = sel ? b_addr  : a_addr;
  assign mem_rd_en    = sel ? b_mem   : a_mem;
  assign rd_gray      = sel ? b_gray  : a_gray;
  assign empty        = sel ? b_empty : a_empty;
  assign almost_empty = sel ? b_ae    : a_ae;
  assign dout_valid   = sel ? b_dv    : a_dv;
  assign rd_level     = sel ? b_level : a_level;
  assign underflow    = sel ? b_uf    : a_uf;

  always #5 clk = ~clk;

  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  // Scoreboard: every RAM read strobe must fetch the oldest unread written address.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (mem_rd_en !== m_fetch) begin
        errors++;
        $display("[TB] FAIL mem_rd_en: got %b expected %b at %0t", mem_rd_en, m_fetch, $time);
      end
      if (mem_rd_en === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_fetch: got fetch with addr %0h expected no fetch (queue empty)", rd_addr);
        end else if (rd_addr !== sb_q[0]) begin
          errors++;
          $display("[TB] FAIL sb_addr: got %0h expected %0h", rd_addr, sb_q[0]);
          void'(sb_q.pop_front());
        end else begin
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset(input logic mode);
    rst = 1'b1;
    rd_en = 1'b0;
    wr_gray = '0;
    sel = mode;
    sb_q.delete();
    m_wr = '0; m_rd = '0; m_level = '0;
    m_ram_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0; m_dv = 1'b0;
    m_empty = 1'b1; m_fetch = 1'b0; m_rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: commit the model for the edge, then apply the new inputs.
  task automatic drive(input int nwr, input logic rd);
    @(posedge clk);
    #1;
    m_uf = m_rd_req & m_empty;
    m_dv = sel & (m_fetch | (m_dv & ~m_rd_req));
    m_rd = m_rd + {{AW{1'b0}}, m_fetch};
    m_ram_empty = (m_rd == m_wr);
    m_level = m_wr - m_rd;
    m_ae = (int'(m_level) <= THRESH);
    m_empty = sel ? ~m_dv : m_ram_empty;
    for (int k = 0; k < nwr; k++) begin
      sb_q.push_back(m_wr[AW-1:0]);
      m_wr = m_wr + {{AW{1'b0}}, 1'b1};
    end
    wr_gray = to_gray(m_wr);
    rd_en = rd;
    m_rd_req = rd;
    m_fetch = sel ? (~m_ram_empty & (~m_dv | rd)) : (rd & ~m_ram_empty);
    #1;
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rst_empty: got %b expected 1", empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL rst_ae: got %b expected 1", almost_empty); end
    checks++; if (rd_level !== '0 || rd_gray !== '0) begin errors++; $display("[TB] FAIL rst_ptr: got level %0d gray %b expected 0 0", rd_level, rd_gray); end
    drive(3, 1'b0);
    drive(0, 1'b0);
    drive(0, 1'b1);
    checks++; if (dout_valid !== 1'b1 || rd_level !== 5'd2 || mem_rd_en !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_rst: got dv %b level %0d mem %b expected 1 2 1", dout_valid, rd_level, mem_rd_en);
    end
    rst = 1'b1;
    #1;
    checks++; if (rd_addr !== '0 || rd_gray !== '0) begin errors++; $display("[TB] FAIL async_ptr: got addr %0h gray %b expected 0 0", rd_addr, rd_gray); end
    checks++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL async_flags: got empty %b ae %b expected 1 1", empty, almost_empty); end
    checks++; if (rd_level !== '0 || dout_valid !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("[TB] FAIL async_misc: got level %0d dv %b uf %b expected 0 0 0", rd_level, dout_valid, underflow);
    end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL async_mem: got %b expected 0", mem_rd_en); end
  endtask

  task automatic test_std_read;
    do_reset(1'b0);
    drive(3, 1'b0);
    drive(0, 1'b0);
    checks++; if (empty !== 1'b0 || rd_level !== 5'd3 || almost_empty !== 1'b0) begin
      errors++; $display("[TB] FAIL std_fill: got empty %b level %0d ae %b expected 0 3 0", empty, rd_level, almost_empty);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1);
      checks++; if (mem_rd_en !== 1'b1 || rd_addr !== (AW)'(i)) begin
        errors++; $display("[TB] FAIL std_pop%0d: got mem %b addr %0h expected 1 %0h", i, mem_rd_en, rd_addr, i);
      end
      checks++; if (rd_level !== (AW+1)'(3 - i) || almost_empty !== ((3 - i) <= THRESH)) begin
        errors++; $display("[TB] FAIL std_level%0d: got level %0d ae %b expected %0d %b", i, rd_level, almost_empty, 3 - i, (3 - i) <= THRESH);
      end
    end
    drive(0, 1'b0);
    checks++; if (empty !== 1'b1 || rd_level !== '0 || almost_empty !== 1'b1) begin
      errors++; $display("[TB] FAIL std_drained: got empty %b level %0d ae %b expected 1 0 1", empty, rd_level, almost_empty);
    end
  endtask

  task automatic test_underflow;
    do_reset(1'b0);
    drive(0, 1'b1);
    drive(0, 1'b1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL uf_first: got %b expected 1", underflow); end
    drive(0, 1'b0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL uf_second: got %b expected 1", underflow); end
    drive(0, 1'b0);
    checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL uf_clear: got %b expected 0", underflow); end
    checks++; if (rd_addr !== '0 || rd_gray !== '0) begin errors++; $display("[TB] FAIL uf_ptr: got addr %0h gray %b expected 0 0", rd_addr, rd_gray); end
  endtask

  task automatic test_wrap;
    logic [AW:0] prev;
    logic        saw_wrap;
    saw_wrap = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1, 1'b0);
      drive(0, 1'b0);
      checks++; if (empty !== 1'b0 || rd_level !== 5'd1) begin
        errors++; $display("[TB] FAIL wrap_fill%0d: got empty %b level %0d expected 0 1", i, empty, rd_level);
      end
      drive(0, 1'b1);
      prev = rd_gray;
      drive(0, 1'b0);
      checks++; if ($countones(rd_gray ^ prev) != 1 || rd_gray !== to_gray((AW+1)'((i + 1) % 32))) begin
        errors++; $display("[TB] FAIL wrap_gray%0d: got %b (was %b) expected %b", i, rd_gray, prev, to_gray((AW+1)'((i + 1) % 32)));
      end
      checks++; if (empty !== 1'b1 || rd_level !== '0) begin
        errors++; $display("[TB] FAIL wrap_empty%0d: got empty %b level %0d expected 1 0", i, empty, rd_level);
      end
      if (prev == 5'b10000 && rd_gray == '0) saw_wrap = 1'b1;
    end
    checks++; if (saw_wrap !== 1'b1) begin errors++; $display("[TB] FAIL wrap_seen: got %b expected 1", saw_wrap); end
  endtask

  task automatic test_fwft;
    do_reset(1'b1);
    drive(1, 1'b0);
    drive(0, 1'b0);
    checks++; if (mem_rd_en !== 1'b1 || dout_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("[TB] FAIL fwft_prefetch: got mem %b dv %b empty %b expected 1 0 1", mem_rd_en, dout_valid, empty);
    end
    drive(0, 1'b0);
    checks++; if (mem_rd_en !== 1'b0 || dout_valid !== 1'b1 || empty !== 1'b0) begin
      errors++; $display("[TB] FAIL fwft_show: got mem %b dv %b empty %b expected 0 1 0", mem_rd_en, dout_valid, empty);
    end
    drive(0, 1'b1);
    drive(0, 1'b0);
    checks++; if (empty !== 1'b1 || dout_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL fwft_pop1: got empty %b dv %b expected 1 0", empty, dout_valid);
    end
    drive(4, 1'b0);
    drive(0, 1'b0);
    checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL fwft_burst_pre: got %b expected 1", mem_rd_en); end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1);
      checks++; if (dout_valid !== 1'b1 || mem_rd_en !== (k < 3)) begin
        errors++; $display("[TB] FAIL fwft_burst%0d: got dv %b mem %b expected 1 %b", k, dout_valid, mem_rd_en, k < 3);
      end
    end
    drive(0, 1'b0);
    checks++; if (dout_valid !== 1'b0 || empty !== 1'b1 || underflow !== 1'b0) begin
      errors++; $display("[TB] FAIL fwft_end: got dv %b empty %b uf %b expected 0 1 0", dout_valid, empty, underflow);
    end
  endtask

  task automatic test_level(input logic mode);
    logic [AW:0] occ;
    logic        wr;
    do_reset(mode);
    for (int c = 0; c < 300; c++) begin
      occ = m_wr - m_rd;
      wr = (int'(occ) < (1 << AW)) && ($urandom_range(0, 1) == 1);
      drive(wr ? 1 : 0, $urandom_range(0, 2) == 0);
      checks++; if (rd_level !== m_level || almost_empty !== (int'(m_level) <= THRESH)) begin
        errors++; $display("[TB] FAIL lvl%0d_%0d: got level %0d ae %b expected %0d %b", mode, c, rd_level, almost_empty, m_level, int'(m_level) <= THRESH);
      end
      checks++; if (empty !== m_empty || dout_valid !== m_dv || underflow !== m_uf) begin
        errors++; $display("[TB] FAIL flg%0d_%0d: got empty %b dv %b uf %b expected %b %b %b", mode, c, empty, dout_valid, underflow, m_empty, m_dv, m_uf);
      end
      checks++; if (mem_rd_en === 1'b1 && m_ram_empty) begin
        errors++; $display("[TB] FAIL pop_empty%0d_%0d: got mem_rd_en 1 expected 0 while RAM empty", mode, c);
      end
    end
    checks++; if (sb_q.size() != int'(m_level) + (m_fetch ? 1 : 0)) begin
      errors++; $display("[TB] FAIL lvl%0d_queue: got %0d pending expected %0d", mode, sb_q.size(), int'(m_level) + (m_fetch ? 1 : 0));
    end
  endtask

  initial begin
    test_reset();
    test_std_read();
    test_underflow();
    test_wrap();
    test_fwft();
    test_level(1'b0);
    test_level(1'b1);
    drive(0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
